ddc_capture_ctrl: RTL and testbench

//  Sequences snapshot capture of the 4-lane I/Q DDC output into on-chip RAM for host readout.
//  - Arm, wait for a trigger, then store cap_len decimated beats.
//  - Stream the stored beats out over a valid/ready port.

---
 rtl/ddc_pkg.sv | 22 ++
 rtl/ddc_cap_ram.sv | 36 +++
 rtl/ddc_capture_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_ddc_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// rtl/ddc_pkg.sv - shared types for the DDC snapshot capture controller
//
// Purpose: default lane geometry, FSM state encoding and the packed I/Q beat
//          type used by ddc_capture_ctrl and ddc_cap_ram.
// Ports:   none (package).

package ddc_pkg;

  localparam int LANES_DEFAULT = 4;
  localparam int IQ_W_DEFAULT  = 28;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    READOUT = 3'd3
  } cap_state_t;

  // {q3,q2,q1,q0,i3,i2,i1,i0}
  typedef logic [2*LANES_DEFAULT*IQ_W_DEFAULT-1:0] iq_beat_t;

endpackage

// File: rtl/ddc_cap_ram.sv
// rtl/ddc_cap_ram.sv - simple dual-port capture RAM with registered read
//
// Purpose: DEPTH x W snapshot storage; one write port, one read port,
//          read data appears the cycle after rd_en.
// Ports:
//   sysclk_i  in   clock
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   write beat
//   rd_en     in   read strobe
//   rd_addr   in   read address
//   rd_data   out  registered read beat (1-cycle latency)

module ddc_cap_ram
  import ddc_pkg::*;
#(
  parameter int W     = $bits(iq_beat_t),
  parameter int DEPTH = 1024
) (
  input  logic                     sysclk_i,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge sysclk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ddc_capture_ctrl.sv
// rtl/ddc_capture_ctrl.sv - arm/trigger snapshot capture of DDC I/Q beats with streamed readout
//
// Purpose: arm, wait for a trig_i rising edge, store cap_len decimated beats
//          into RAM, then stream them out over a valid/ready port.
// Optional feature: define DDC_CAP_TIMESTAMP_EN to add trig_ts_o, the count
//          of iq_valid_i beats since reset latched at the trigger.
// Ports:
//   sysclk_i    in   clock, all logic on rising edge
//   rst_i       in   synchronous reset, active-high
//   arm_i       in   start request (IDLE only)
//   abort_i     in   return to IDLE from any state
//   trig_i      in   trigger level, rising edge used
//   cap_len_i   in   beats to capture (0 or >DEPTH means DEPTH), sampled on arm
//   dec_i       in   store 1 of every dec_i+1 valid beats, sampled on arm
//   iq_valid_i  in   input beat valid
//   iq_data_i   in   input beat {q3..q0,i3..i0}
//   rd_valid_o  out  readout beat valid
//   rd_ready_i  in   readout accept
//   rd_data_o   out  readout beat
//   rd_last_o   out  final beat of the snapshot
//   state_o     out  current cap_state_t
//   busy_o      out  state != IDLE
//   trig_ts_o   out  trigger timestamp (DDC_CAP_TIMESTAMP_EN only)
//   done_o      out  1-cycle pulse after the last readout handshake

module ddc_capture_ctrl
  import ddc_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int IQ_W  = IQ_W_DEFAULT,
  parameter int DEPTH = 1024,
  parameter int DEC_W = 16
) (
  input  logic                      sysclk_i,
  input  logic                      rst_i,
  input  logic                      arm_i,
  input  logic                      abort_i,
  input  logic                      trig_i,
  input  logic [$clog2(DEPTH):0]    cap_len_i,
  input  logic [DEC_W-1:0]          dec_i,
  input  logic                      iq_valid_i,
  input  logic [2*LANES*IQ_W-1:0]   iq_data_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [2*LANES*IQ_W-1:0]   rd_data_o,
  output logic                      rd_last_o,
  output logic [2:0]                state_o,
  output logic                      busy_o,
`ifdef DDC_CAP_TIMESTAMP_EN
  output logic [31:0]               trig_ts_o,
`endif
  output logic                      done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2*LANES*IQ_W;
  localparam logic [AW:0]      LEN_ONE = (AW+1)'(1);
  localparam logic [AW:0]      LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [DEC_W-1:0] DEC_ONE = DEC_W'(1);

  cap_state_t      state;
  logic            trig_q;
  logic [AW:0]     len_q;
  logic [AW:0]     wcnt;
  logic [AW:0]     raddr;
  logic [DEC_W-1:0] dec_q;
  logic [DEC_W-1:0] dec_cnt;

  // Readout pipeline: a RAM read in flight (pend) plus a head register that
  // drives the port and one skid entry that absorbs data landing during a stall.
  logic            pend;
  logic            pend_last;
  logic            skid_valid;
  logic            skid_last;
  logic [DW-1:0]   skid_data;
  logic [DW-1:0]   ram_q;

  logic            trig_edge;
  logic            cap_window;
  logic            wr_en;
  logic            pop;
  logic [1:0]      occ;
  logic            rd_issue;

  assign trig_edge  = trig_i & ~trig_q;
  // The trigger cycle itself counts as capture so its beat becomes beat 0.
  assign cap_window = (state == CAPTURE) || (state == ARMED && trig_edge);
  assign wr_en      = !abort_i && cap_window && iq_valid_i && (dec_cnt == '0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign occ        = 2'(rd_valid_o) + 2'(skid_valid) + 2'(pend);
  // Issue only if the returning beat is guaranteed a free slot next cycle.
  assign rd_issue   = (state == READOUT) && !abort_i && (raddr < len_q) &&
                      ((occ - 2'(pop)) <= 2'd1);

  assign state_o = state;
  assign busy_o  = (state != IDLE);

  ddc_cap_ram #(.W(DW), .DEPTH(DEPTH)) u_ram (
    .sysclk_i (sysclk_i),
    .wr_en    (wr_en),
    .wr_addr  (wcnt[AW-1:0]),
    .wr_data  (iq_data_i),
    .rd_en    (rd_issue),
    .rd_addr  (raddr[AW-1:0]),
    .rd_data  (ram_q)
  );

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      len_q      <= '0;
      dec_q      <= '0;
      dec_cnt    <= '0;
      wcnt       <= '0;
      raddr      <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      rd_data_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      trig_q <= trig_i;
      done_o <= 1'b0;
      if (abort_i) begin
        state      <= IDLE;
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
        skid_valid <= 1'b0;
        pend       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_i) begin
              state   <= ARMED;
              len_q   <= (cap_len_i == '0 || cap_len_i > LEN_MAX) ? LEN_MAX : cap_len_i;
              dec_q   <= dec_i;
              dec_cnt <= '0;
              wcnt    <= '0;
              raddr   <= '0;
            end
          end
          ARMED, CAPTURE: begin
            if (cap_window) begin
              if (state == ARMED) state <= CAPTURE;
              if (iq_valid_i) dec_cnt <= (dec_cnt == dec_q) ? '0 : dec_cnt + DEC_ONE;
              if (wr_en) begin
                wcnt <= wcnt + LEN_ONE;
                if (wcnt == len_q - LEN_ONE) state <= READOUT;
              end
            end
          end
          READOUT: begin
            pend <= rd_issue;
            if (rd_issue) begin
              raddr     <= raddr + LEN_ONE;
              pend_last <= (raddr == len_q - LEN_ONE);
            end
            if (pop) begin
              if (skid_valid) begin
                rd_data_o  <= skid_data;
                rd_last_o  <= skid_last;
                skid_valid <= pend;
                skid_data  <= ram_q;
                skid_last  <= pend_last;
              end else begin
                rd_valid_o <= pend;
                rd_data_o  <= ram_q;
                rd_last_o  <= pend & pend_last;
              end
              if (rd_last_o) begin
                state      <= IDLE;
                done_o     <= 1'b1;
                rd_valid_o <= 1'b0;
                rd_last_o  <= 1'b0;
                skid_valid <= 1'b0;
                pend       <= 1'b0;
              end
            end else if (pend) begin
              if (!rd_valid_o) begin
                rd_valid_o <= 1'b1;
                rd_data_o  <= ram_q;
                rd_last_o  <= pend_last;
              end else begin
                skid_valid <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= pend_last;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DDC_CAP_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      ts_cnt    <= '0;
      trig_ts_o <= '0;
    end else begin
      if (iq_valid_i) ts_cnt <= ts_cnt + 32'd1;
      // Latch the count of beats seen before the trigger cycle.
      if (!abort_i && state == ARMED && trig_edge) trig_ts_o <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ddc_capture_ctrl.sv
// tb/tb_ddc_capture_ctrl.sv - self-checking bench for ddc_capture_ctrl

module tb_ddc_capture_ctrl;

  typedef logic [223:0] beat_t;

  typedef struct {
    int cap_len;
    int dec;
    int hole_pct;
    int rdy_pct;
    int pre_valid;
    bit trig_pre;
    int abort_after;
    int exp_len;
  } vec_t;

  logic         sysclk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         arm_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         trig_i = 1'b0;
  logic [10:0]  cap_len_i = '0;
  logic [15:0]  dec_i = '0;
  logic         iq_valid_i = 1'b0;
  beat_t        iq_data_i = '0;
  logic         rd_valid_o;
  logic         rd_ready_i = 1'b0;
  beat_t        rd_data_o;
  logic         rd_last_o;
  logic [2:0]   state_o;
  logic         busy_o;
  logic         done_o;
`ifdef DDC_CAP_TIMESTAMP_EN
  logic [31:0]  trig_ts_o;
`endif

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  vec_t  vecs[8];

  ddc_capture_ctrl dut (
    .sysclk_i   (sysclk_i),
    .rst_i      (rst_i),
    .arm_i      (arm_i),
    .abort_i    (abort_i),
    .trig_i     (trig_i),
    .cap_len_i  (cap_len_i),
    .dec_i      (dec_i),
    .iq_valid_i (iq_valid_i),
    .iq_data_i  (iq_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_data_o  (rd_data_o),
    .rd_last_o  (rd_last_o),
    .state_o    (state_o),
    .busy_o     (busy_o),
`ifdef DDC_CAP_TIMESTAMP_EN
    .trig_ts_o  (trig_ts_o),
`endif
    .done_o     (done_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sysclk_i);
    #1;
  endtask

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int n);
    beat_t b;
    b = '0;
    for (int l = 0; l < 8; l++) b[l*28 +: 28] = {4'(l), n[23:0]};
    return b;
  endfunction

  task automatic recover();
    abort_i = 1'b1;
    rd_ready_i = 1'b0;
    iq_valid_i = 1'b0;
    trig_i = 1'b0;
    step();
    abort_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_snap(input vec_t v, input int n0);
    int n, cyc, budget, rcyc, got, first_v, bubbles, done_seen;
    bit vb, rdy, pv, pr, pl;
    beat_t pd, e;
    exp_q.delete();
    trig_i = v.trig_pre;
    step();
    arm_i = 1'b1;
    cap_len_i = 11'(v.cap_len);
    dec_i = 16'(v.dec);
    step();
    arm_i = 1'b0;
    chk("armed", beat_t'(state_o), beat_t'(1));
    for (int j = 0; j < 2*v.pre_valid; j++) begin
      iq_valid_i = j[0];
      iq_data_i = mk_beat(32'hABC000 + j);
      step();
    end
    iq_valid_i = 1'b0;
    chk("still_armed", beat_t'(state_o), beat_t'(1));
    trig_i = 1'b0;
    step();

    n = n0;
    cyc = 0;
    budget = v.exp_len*(v.dec+1)*4 + 64;
    while (state_o != 3'd3) begin
      if (cyc >= budget) begin
        chk("capture_timeout", beat_t'(state_o), beat_t'(3));
        recover();
        return;
      end
      vb = int'($urandom_range(99)) >= v.hole_pct;
      iq_valid_i = vb;
      iq_data_i = mk_beat(n);
      trig_i = (cyc == 0) || (cyc % 3 != 1);
      if (vb && ((n - n0) % (v.dec + 1)) == 0 && exp_q.size() < v.exp_len)
        exp_q.push_back(mk_beat(n));
      step();
      if (vb) n++;
      cyc++;
    end
    iq_valid_i = 1'b0;
    trig_i = 1'b0;

    got = 0; rcyc = 0; first_v = -1; bubbles = 0; done_seen = 0;
    pv = 0; pr = 0; pl = 0; pd = '0;
    while (got < v.exp_len) begin
      if (rcyc >= v.exp_len*20 + 64) begin
        chk("readout_timeout", beat_t'(got), beat_t'(v.exp_len));
        recover();
        return;
      end
      if (done_o) done_seen++;
      if (rd_valid_o && first_v < 0) first_v = rcyc;
      if (first_v >= 0 && !rd_valid_o) bubbles++;
      if (pv && !pr) begin
        chk("stall_valid", beat_t'(rd_valid_o), beat_t'(1));
        chk("stall_data", rd_data_o, pd);
        chk("stall_last", beat_t'(rd_last_o), beat_t'(pl));
      end
      if (v.abort_after >= 0 && got == v.abort_after) break;
      rdy = int'($urandom_range(99)) < v.rdy_pct;
      rd_ready_i = rdy;
      if (rd_valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", beat_t'(1), beat_t'(0));
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
        chk("rd_data", rd_data_o, e);
        chk("rd_last", beat_t'(rd_last_o), beat_t'(got == v.exp_len - 1));
        got++;
      end
      pv = rd_valid_o; pr = rdy; pd = rd_data_o; pl = rd_last_o;
      step();
      rcyc++;
    end
    chk("latency", beat_t'(first_v >= 0 && first_v <= 2), beat_t'(1));

    if (v.abort_after >= 0) begin
      abort_i = 1'b1;
      arm_i = 1'b1;
      cap_len_i = 11'd2;
      rd_ready_i = 1'b0;
      step();
      abort_i = 1'b0;
      arm_i = 1'b0;
      chk("abort_state", beat_t'(state_o), beat_t'(0));
      chk("abort_valid", beat_t'(rd_valid_o), beat_t'(0));
      for (int j = 0; j < 4; j++) begin
        if (done_o) done_seen++;
        step();
      end
      chk("abort_no_done", beat_t'(done_seen), beat_t'(0));
      chk("abort_idle", beat_t'(busy_o), beat_t'(0));
      exp_q.delete();
      return;
    end

    rd_ready_i = 1'b0;
    chk("done_pulse", beat_t'(done_o), beat_t'(1));
    chk("done_early", beat_t'(done_seen), beat_t'(0));
    chk("end_state", beat_t'(state_o), beat_t'(0));
    chk("end_valid", beat_t'(rd_valid_o), beat_t'(0));
    if (v.rdy_pct == 100) chk("bubbles", beat_t'(bubbles), beat_t'(0));
    step();
    chk("done_single", beat_t'(done_o), beat_t'(0));
    chk("end_busy", beat_t'(busy_o), beat_t'(0));
    chk("sb_empty", beat_t'(exp_q.size()), beat_t'(0));
  endtask

  initial begin
    vec_t extra;
    //            len  dec hole rdy pre  tp  abort exp
    vecs[0] = '{8,    0,  0,  100, 37, 1'b0, -1, 8};
    vecs[1] = '{4,    2,  30, 100, 3,  1'b1, -1, 4};
    vecs[2] = '{16,   0,  0,  50,  0,  1'b0, -1, 16};
    vecs[3] = '{0,    0,  0,  100, 0,  1'b0, -1, 1024};
    vecs[4] = '{1029, 0,  10, 70,  2,  1'b0, -1, 1024};
    vecs[5] = '{8,    0,  0,  100, 0,  1'b0, 3,  8};
    vecs[6] = '{5,    1,  20, 60,  1,  1'b1, -1, 5};
    vecs[7] = '{1,    3,  0,  30,  0,  1'b0, -1, 1};

    rst_i = 1'b1;
    repeat (3) step();
    chk("rst_state", beat_t'(state_o), beat_t'(0));
    chk("rst_valid", beat_t'(rd_valid_o), beat_t'(0));
    chk("rst_last", beat_t'(rd_last_o), beat_t'(0));
    chk("rst_data", rd_data_o, beat_t'(0));
    chk("rst_busy", beat_t'(busy_o), beat_t'(0));
    chk("rst_done", beat_t'(done_o), beat_t'(0));
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_snap(vecs[i], 1000*i + 16);
`ifdef DDC_CAP_TIMESTAMP_EN
      if (i == 0) chk("trig_ts", beat_t'(trig_ts_o), beat_t'(37));
`endif
    end

    arm_i = 1'b1;
    cap_len_i = 11'd8;
    dec_i = 16'd0;
    step();
    arm_i = 1'b0;
    trig_i = 1'b1;
    iq_valid_i = 1'b1;
    iq_data_i = mk_beat(32'h5555);
    repeat (3) step();
    chk("midcap_state", beat_t'(state_o), beat_t'(2));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    iq_valid_i = 1'b0;
    trig_i = 1'b0;
    chk("midrst_state", beat_t'(state_o), beat_t'(0));
    chk("midrst_busy", beat_t'(busy_o), beat_t'(0));
    chk("midrst_valid", beat_t'(rd_valid_o), beat_t'(0));
    chk("midrst_done", beat_t'(done_o), beat_t'(0));
    extra = '{3, 0, 0, 100, 0, 1'b0, -1, 3};
    run_snap(extra, 9000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
